// File: rtl/base2_alu_iter.sv
// Multi-cycle base-2 ALU: single-cycle logic/arith ops plus iterative shift-add multiply
// and restoring divide, behind a start/ready/valid handshake.
module base2_alu_iter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             valid,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             err
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd = 4'h0;
  localparam logic [3:0] OpSub = 4'h1;
  localparam logic [3:0] OpMul = 4'h2;
  localparam logic [3:0] OpDiv = 4'h3;
  localparam logic [3:0] OpAnd = 4'h4;
  localparam logic [3:0] OpOr  = 4'h5;
  localparam logic [3:0] OpXor = 4'h6;
  localparam logic [3:0] OpShl = 4'h7;
  localparam logic [3:0] OpShr = 4'h8;
  localparam logic [3:0] OpAsr = 4'h9;

  typedef enum logic [1:0] {StIdle, StExec, StIter, StFin} state_e;

  state_e state_q, state_d;

  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc_q, acc_step;
  logic [CntW-1:0]    cnt_q;
  logic               accept, last_iter, go_iter;

  assign accept    = start && ready;
  assign last_iter = (cnt_q == CntW'(WIDTH - 1));
  assign go_iter   = (operation == OpMul) || ((operation == OpDiv) && (operand_b != '0));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = go_iter ? StIter : StExec;
      StExec:  state_d = StIdle;
      StIter:  if (last_iter) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready = (state_q == StIdle);
  end

  // Iteration step: acc holds {partial product, multiplier} for MUL, {remainder, quotient}
  // for DIV; both shift one bit per cycle.
  logic [WIDTH:0] mul_sum, div_shift, div_diff;
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, b_q};

  always_comb begin
    acc_step = acc_q;
    if (op_q == OpMul) begin
      if (acc_q[0]) acc_step = {mul_sum, acc_q[WIDTH-1:1]};
      else          acc_step = {1'b0, acc_q[2*WIDTH-1:1]};
    end else begin
      if (!div_diff[WIDTH]) acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      op_q  <= operation;
      a_q   <= operand_a;
      b_q   <= operand_b;
      acc_q <= (operation == OpMul) ? {{WIDTH{1'b0}}, operand_b} : {{WIDTH{1'b0}}, operand_a};
      cnt_q <= '0;
    end else if (state_q == StIter) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Single-cycle datapath
  logic [SHW-1:0]          sh;
  logic [WIDTH:0]          add_full, sub_full, shl_full;
  logic signed [WIDTH-1:0] a_s;
  logic [WIDTH-1:0]        asr_res;
  logic [WIDTH-1:0]        ex_res, ex_hi;
  logic                    ex_carry, ex_ovf, ex_err;

  assign sh       = b_q[SHW-1:0];
  assign add_full = {1'b0, a_q} + {1'b0, b_q};
  assign sub_full = {1'b0, a_q} - {1'b0, b_q};
  assign shl_full = {1'b0, a_q} << sh;
  assign a_s      = a_q;
  assign asr_res  = a_s >>> sh;

  always_comb begin
    ex_res   = '0;
    ex_hi    = '0;
    ex_carry = 1'b0;
    ex_ovf   = 1'b0;
    ex_err   = 1'b0;
    case (op_q)
      OpAdd: begin
        ex_res   = add_full[WIDTH-1:0];
        ex_carry = add_full[WIDTH];
        ex_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_full[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpSub: begin
        ex_res   = sub_full[WIDTH-1:0];
        ex_carry = sub_full[WIDTH];
        ex_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_full[WIDTH-1] != a_q[WIDTH-1]);
      end
      // Only divide-by-zero reaches here; the dividend is reported as the remainder.
      OpDiv: begin
        ex_hi  = a_q;
        ex_err = 1'b1;
      end
      OpAnd: ex_res = a_q & b_q;
      OpOr:  ex_res = a_q | b_q;
      OpXor: ex_res = a_q ^ b_q;
      OpShl: begin
        ex_res   = shl_full[WIDTH-1:0];
        ex_carry = shl_full[WIDTH];
      end
      OpShr: ex_res = a_q >> sh;
      OpAsr: ex_res = asr_res;
      default: ex_err = 1'b1;
    endcase
  end

  logic [WIDTH-1:0] out_res, out_hi;
  logic             out_carry, out_ovf, out_err;

  always_comb begin
    if (state_q == StFin) begin
      out_res   = acc_q[WIDTH-1:0];
      out_hi    = acc_q[2*WIDTH-1:WIDTH];
      out_carry = 1'b0;
      out_ovf   = (op_q == OpMul) && (acc_q[2*WIDTH-1:WIDTH] != '0);
      out_err   = 1'b0;
    end else begin
      out_res   = ex_res;
      out_hi    = ex_hi;
      out_carry = ex_carry;
      out_ovf   = ex_ovf;
      out_err   = ex_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      result_hi <= '0;
      valid     <= 1'b0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
    end else begin
      valid <= 1'b0;
      if ((state_q == StExec) || (state_q == StFin)) begin
        result    <= out_res;
        result_hi <= out_hi;
        valid     <= 1'b1;
        zero      <= (out_res == '0);
        carry     <= out_carry;
        overflow  <= out_ovf;
        err       <= out_err;
      end
    end
  end

endmodule

// File: tb/tb_base2_alu_iter.sv
// Directed bench for base2_alu_iter at WIDTH=16: hand-computed vectors, latency and
// handshake checks.
module tb_base2_alu_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  operation = 4'h0;
  logic [15:0] operand_a = '0;
  logic [15:0] operand_b = '0;
  logic        ready, valid, zero, carry, overflow, err;
  logic [15:0] result, result_hi;

  int n_checks = 0;
  int n_errors = 0;

  base2_alu_iter #(.WIDTH(16), .SHW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .operation (operation),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .ready     (ready),
    .result    (result),
    .result_hi (result_hi),
    .valid     (valid),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a request so the next rising edge accepts it; returns #1 after that edge.
  task automatic start_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    start     = 1'b1;
    operation = op;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until valid; lat=-1 on timeout. rdy_seen flags ready=1 before valid.
  task automatic wait_valid(output int lat, output bit rdy_seen);
    lat      = -1;
    rdy_seen = ready;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = i;
        break;
      end
      if (ready) rdy_seen = 1'b1;
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] r, input logic [15:0] h,
                           input bit z, input bit c, input bit o, input bit e);
    check_eq({tag, ".result"}, 32'(result), 32'(r));
    check_eq({tag, ".result_hi"}, 32'(result_hi), 32'(h));
    check_eq({tag, ".zero"}, 32'(zero), 32'(z));
    check_eq({tag, ".carry"}, 32'(carry), 32'(c));
    check_eq({tag, ".overflow"}, 32'(overflow), 32'(o));
    check_eq({tag, ".err"}, 32'(err), 32'(e));
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    int          lat;
    logic [15:0] r, h;
    bit          z, c, o, e;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat;
    bit rdy_seen;
    int nvalid;

    vecs.push_back('{4'h0, 16'hFFFF, 16'h0001,  1, 16'h0000, 16'h0000, 1, 1, 0, 0});
    vecs.push_back('{4'h1, 16'h8000, 16'h0001,  1, 16'h7FFF, 16'h0000, 0, 0, 1, 0});
    vecs.push_back('{4'h2, 16'h1234, 16'h5678, 17, 16'h0060, 16'h0626, 0, 0, 1, 0});
    vecs.push_back('{4'h3, 16'h03E8, 16'h0007, 17, 16'h008E, 16'h0006, 0, 0, 0, 0});
    vecs.push_back('{4'h3, 16'h1234, 16'h0000,  1, 16'h0000, 16'h1234, 1, 0, 0, 1});
    vecs.push_back('{4'h4, 16'hF0F0, 16'h3C3C,  1, 16'h3030, 16'h0000, 0, 0, 0, 0});
    vecs.push_back('{4'h5, 16'hF000, 16'h000F,  1, 16'hF00F, 16'h0000, 0, 0, 0, 0});
    vecs.push_back('{4'h7, 16'h8001, 16'h0001,  1, 16'h0002, 16'h0000, 0, 1, 0, 0});
    vecs.push_back('{4'h7, 16'h8001, 16'h0000,  1, 16'h8001, 16'h0000, 0, 0, 0, 0});
    vecs.push_back('{4'h8, 16'h8000, 16'h0004,  1, 16'h0800, 16'h0000, 0, 0, 0, 0});
    vecs.push_back('{4'hA, 16'h1234, 16'h5678,  1, 16'h0000, 16'h0000, 1, 0, 0, 1});
    vecs.push_back('{4'h2, 16'h0003, 16'h0005, 17, 16'h000F, 16'h0000, 0, 0, 0, 0});

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst.ready", 32'(ready), 32'd1);
    check_eq("rst.valid", 32'(valid), 32'd0);
    check_out("rst", 16'h0, 16'h0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("v%0d_op%0h", i, vecs[i].op);
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      check_eq({tag, ".busy"}, 32'(ready), 32'd0);
      wait_valid(lat, rdy_seen);
      check_eq({tag, ".lat"}, 32'(lat), 32'(vecs[i].lat));
      check_eq({tag, ".rdy_early"}, 32'(rdy_seen), 32'd0);
      check_out(tag, vecs[i].r, vecs[i].h, vecs[i].z, vecs[i].c, vecs[i].o, vecs[i].e);
      check_eq({tag, ".rdy_valid"}, 32'(ready), 32'd1);
      @(posedge clk);
      #1;
      check_eq({tag, ".pulse"}, 32'(valid), 32'd0);
    end

    // Back-to-back: XOR accepted on the MUL valid cycle
    start_op(4'h2, 16'h1234, 16'h5678);
    wait_valid(lat, rdy_seen);
    check_eq("b2b.mul_lat", 32'(lat), 32'd17);
    start_op(4'h6, 16'h00FF, 16'h0F0F);
    check_eq("b2b.gap", 32'(valid), 32'd0);
    @(posedge clk);
    #1;
    check_eq("b2b.xor_valid", 32'(valid), 32'd1);
    check_out("b2b", 16'h0FF0, 16'h0000, 0, 0, 0, 0);

    // start mid-MUL ignored; operand changes after accept do not matter
    start_op(4'h2, 16'h0010, 16'h0020);
    repeat (4) @(posedge clk);
    #1;
    start_op(4'h0, 16'h1111, 16'h2222);
    operand_a = 16'hAAAA;
    wait_valid(lat, rdy_seen);
    check_eq("mid.lat", 32'(lat), 32'd12);
    check_out("mid", 16'h0200, 16'h0000, 0, 0, 0, 0);
    nvalid = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (valid) nvalid++;
    end
    check_eq("mid.extra_valid", 32'(nvalid), 32'd0);

    // Reset mid-MUL
    start_op(4'h2, 16'hFFFF, 16'hFFFF);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rmid.ready", 32'(ready), 32'd1);
    check_eq("rmid.valid", 32'(valid), 32'd0);
    check_out("rmid", 16'h0, 16'h0, 0, 0, 0, 0);
    nvalid = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (valid) nvalid++;
    end
    check_eq("rmid.no_valid", 32'(nvalid), 32'd0);
    start_op(4'h9, 16'h8000, 16'h0003);
    wait_valid(lat, rdy_seen);
    check_eq("asr.lat", 32'(lat), 32'd1);
    check_out("asr", 16'hF000, 16'h0000, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/base2_alu_iter.md
Name: base2_alu_iter

Overview:
- Parametrised, multi-cycle successor to the team's 16-bit binary ALU.
- Adds a generic datapath width and iterative multiply and divide (one bit per cycle, no wide multiplier or divider inferred).
- Adds a start/ready/valid handshake, a high-half result (product upper half or remainder) and status flags.
- Sits in the same compute cluster as the other base-N ALUs and is driven by the op dispatcher.

Parameters:
WIDTH, 16, operand/result width in bits (>=4)
SHW, 4, shift-amount bits taken from operand_b[SHW-1:0]; must satisfy 2^SHW == WIDTH

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted when start && ready at a rising edge
operation  input  4  opcode, sampled at accept
operand_a  input  WIDTH  sampled at accept
operand_b  input  WIDTH  sampled at accept
ready  output  1  high when idle and able to accept
result  output  WIDTH  low result: sum, difference, product[WIDTH-1:0], quotient, logic or shift value
result_hi  output  WIDTH  product[2*WIDTH-1:WIDTH] for MUL, remainder for DIV; 0 for all other ops
valid  output  1  one-cycle pulse; result, result_hi and flags are valid and held until the next valid
zero  output  1  result == 0
carry  output  1  ADD carry-out; SUB borrow; SHL last bit shifted out; 0 otherwise
overflow  output  1  signed overflow for ADD/SUB; result_hi != 0 for MUL; 0 otherwise
err  output  1  DIV with operand_b == 0, or illegal opcode

Behaviour:
- Interface: one clock domain, clk; reset synchronous, active-high. Reset sets state IDLE, ready=1, valid=0, and result, result_hi, zero, carry, overflow, err all 0; clears the iteration counter.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 AND, 0101 OR, 0110 XOR, 0111 SHL, 1000 SHR (logical), 1001 ASR (arithmetic).
  - Any other opcode is illegal: result=0, result_hi=0, err=1, latency 1.
- States:
  - IDLE: ready=1. On accept, latch opcode and operands. MUL/DIV with nonzero divisor -> ITER; everything else -> EXEC.
  - EXEC: one cycle; computes, registers outputs, pulses valid, -> IDLE.
  - ITER: WIDTH cycles with a counter 0..WIDTH-1.
    - MUL: shift-add on a 2*WIDTH accumulator.
    - DIV: restoring divide, one quotient bit per cycle.
    - After the last step -> FIN.
  - FIN: registers result/result_hi/flags, pulses valid, -> IDLE.
- Latency from the accept edge k:
  - EXEC ops: outputs update and valid=1 after edge k+1.
  - MUL/DIV: outputs update and valid=1 after edge k+WIDTH+1.
- ready is low from edge k until the state returns to IDLE. ready=1 during the valid cycle, so back-to-back accept is allowed and the next op starts on that edge.
- start while ready=0 is ignored (no queueing). Operand and opcode changes after accept have no effect.
- Arithmetic:
  - All ops are unsigned, except the overflow flag for ADD/SUB and the ASR sign fill.
  - ADD/SUB are computed at WIDTH+1 bits for carry/borrow.
  - Shift amount = operand_b[SHW-1:0]; a shift of 0 gives carry=0.
- DIV by zero: takes the EXEC path. result=0, result_hi=operand_a, err=1, overflow=0.
- zero reflects result only (not result_hi).
- Flags and outputs are undefined-free: every valid pulse rewrites all seven output fields.
- Reset mid-operation (any state) aborts with no valid pulse; ready=1 in the cycle after the reset edge.

Test Plan:
- ADD 0xFFFF+0x0001, WIDTH=16 -> valid one cycle after accept; result=0x0000, zero=1, carry=1, overflow=0, result_hi=0.
- SUB 0x8000-0x0001 -> result=0x7FFF, overflow=1, carry=0.
- MUL 0x1234*0x5678 -> valid exactly 17 cycles after accept; result=0x0060, result_hi=0x0626, overflow=1. ready=0 for cycles 1..16.
- DIV 0x03E8/0x0007 -> result=0x008E, result_hi=0x0006, err=0. Then DIV 0x1234/0x0000 -> one-cycle latency; result=0, result_hi=0x1234, err=1.
- Back-to-back and handshake:
  - Assert start with XOR 0x00FF^0x0F0F on the valid cycle of a MUL -> XOR accepted, valid next cycle with result=0x0FF0.
  - start pulsed mid-MUL is ignored (exactly one valid).
- Reset at cycle 5 of a MUL -> no valid pulse, all outputs 0, ready=1 next cycle. A new ASR 0x8000 by 3 then gives result=0xF000.
